// File: rtl/cordic_stream_arbiter.sv
// cordic_stream_arbiter
// Shares one CORDIC AXI-Stream pipeline between two requesters. The forward
// path grants whole packets round-robin; a 1-bit tag FIFO remembers who owns
// each packet inside the CORDIC so the results can be steered back in order.
module cordic_stream_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                           s00_axis_aclk,
  input  logic                           s00_axis_aresetn,
  input  logic                           s00_axis_tvalid,
  input  logic                           s00_axis_tlast,
  input  logic [DATA_WIDTH-1:0]          s00_axis_tdata,
  output logic                           s00_axis_tready,
  input  logic                           s01_axis_tvalid,
  input  logic                           s01_axis_tlast,
  input  logic [DATA_WIDTH-1:0]          s01_axis_tdata,
  output logic                           s01_axis_tready,
  output logic                           m00_axis_tvalid,
  output logic                           m00_axis_tlast,
  output logic [DATA_WIDTH-1:0]          m00_axis_tdata,
  input  logic                           m00_axis_tready,
  input  logic                           s02_axis_tvalid,
  input  logic                           s02_axis_tlast,
  input  logic [DATA_WIDTH-1:0]          s02_axis_tdata,
  output logic                           s02_axis_tready,
  output logic                           m01_axis_tvalid,
  output logic                           m01_axis_tlast,
  output logic [DATA_WIDTH-1:0]          m01_axis_tdata,
  input  logic                           m01_axis_tready,
  output logic                           m02_axis_tvalid,
  output logic                           m02_axis_tlast,
  output logic [DATA_WIDTH-1:0]          m02_axis_tdata,
  input  logic                           m02_axis_tready,
  output logic [1:0]                     grant,
  output logic [$clog2(TAG_DEPTH+1)-1:0] tags_in_flight
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

  logic [1:0]       rst_sync_r;
  logic             rst_n_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic             rr_r;
  logic             rr_nxt_s;
  logic             tag_mem_r [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             push_tag_s;
  logic             pop_s;
  logic             head_s;
  logic             empty_s;

  // Reset synchronizer: assertion is immediate, release is aligned to the clock.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s        = rst_sync_r[1];
  assign tags_in_flight = count_r;

  // Forward FSM: pick a source in IDLE, then pass its packet straight through until tlast.
  always_comb begin
    state_nxt_s     = state_r;
    rr_nxt_s        = rr_r;
    push_s          = 1'b0;
    push_tag_s      = 1'b0;
    grant           = 2'b00;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    m00_axis_tdata  = {DATA_WIDTH{1'b0}};
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((count_r < FULL_CNT) && (s00_axis_tvalid || s01_axis_tvalid)) begin
          push_s = 1'b1;
          if (s00_axis_tvalid && s01_axis_tvalid) begin
            push_tag_s = rr_r;
          end else begin
            push_tag_s = s01_axis_tvalid;
          end
          state_nxt_s = push_tag_s ? ST_BUSY1 : ST_BUSY0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY0: begin
        grant           = 2'b01;
        m00_axis_tvalid = s00_axis_tvalid;
        m00_axis_tlast  = s00_axis_tlast;
        m00_axis_tdata  = s00_axis_tdata;
        s00_axis_tready = m00_axis_tready;
        if (s00_axis_tvalid && m00_axis_tready && s00_axis_tlast) begin
          state_nxt_s = ST_IDLE;
          rr_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = ST_BUSY0;
        end
      end
      ST_BUSY1: begin
        grant           = 2'b10;
        m00_axis_tvalid = s01_axis_tvalid;
        m00_axis_tlast  = s01_axis_tlast;
        m00_axis_tdata  = s01_axis_tdata;
        s01_axis_tready = m00_axis_tready;
        if (s01_axis_tvalid && m00_axis_tready && s01_axis_tlast) begin
          state_nxt_s = ST_IDLE;
          rr_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = ST_BUSY1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Return path: the head tag steers CORDIC results to their owner; pop on the last beat.
  always_comb begin
    head_s          = tag_mem_r[rd_ptr_r];
    empty_s         = (count_r == {CNT_W{1'b0}});
    s02_axis_tready = 1'b0;
    m01_axis_tvalid = 1'b0;
    m01_axis_tlast  = 1'b0;
    m01_axis_tdata  = {DATA_WIDTH{1'b0}};
    m02_axis_tvalid = 1'b0;
    m02_axis_tlast  = 1'b0;
    m02_axis_tdata  = {DATA_WIDTH{1'b0}};
    if (!empty_s) begin
      if (head_s == 1'b0) begin
        m01_axis_tvalid = s02_axis_tvalid;
        m01_axis_tlast  = s02_axis_tlast;
        m01_axis_tdata  = s02_axis_tdata;
        s02_axis_tready = m01_axis_tready;
      end else begin
        m02_axis_tvalid = s02_axis_tvalid;
        m02_axis_tlast  = s02_axis_tlast;
        m02_axis_tdata  = s02_axis_tdata;
        s02_axis_tready = m02_axis_tready;
      end
    end else begin
      s02_axis_tready = 1'b0;
    end
    pop_s = (!empty_s) && s02_axis_tvalid && s02_axis_tready && s02_axis_tlast;
  end

  // Arbiter state and round-robin pointer.
  always_ff @(posedge s00_axis_aclk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= ST_IDLE;
      rr_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rr_r    <= rr_nxt_s;
    end
  end

  // Tag FIFO storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge s00_axis_aclk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_r[i] <= 1'b0;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= push_tag_s;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_stream_arbiter.sv
// Self-checking bench for cordic_stream_arbiter: directed steps followed by a
// randomized two-requester run checked against a packet-level reference model.
module tb_cordic_stream_arbiter;

  localparam int DW = 64;
  localparam int TD = 4;

  typedef struct packed {
    logic          src;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          s00_axis_aclk = 1'b0;
  logic          s00_axis_aresetn;
  logic          s00_axis_tvalid, s00_axis_tlast, s00_axis_tready;
  logic [DW-1:0] s00_axis_tdata;
  logic          s01_axis_tvalid, s01_axis_tlast, s01_axis_tready;
  logic [DW-1:0] s01_axis_tdata;
  logic          m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
  logic [DW-1:0] m00_axis_tdata;
  logic          s02_axis_tvalid, s02_axis_tlast, s02_axis_tready;
  logic [DW-1:0] s02_axis_tdata;
  logic          m01_axis_tvalid, m01_axis_tlast, m01_axis_tready;
  logic [DW-1:0] m01_axis_tdata;
  logic          m02_axis_tvalid, m02_axis_tlast, m02_axis_tready;
  logic [DW-1:0] m02_axis_tdata;
  logic [1:0]    grant;
  logic [2:0]    tags_in_flight;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  beat_t req_q0[$], req_q1[$], tmp0[$], tmp1[$];
  beat_t fwd_exp[$], ret0[$], ret1[$], cord_q[$];
  int    lens0[$], lens1[$];
  beat_t b, e;
  int    len, cyc;
  logic  rr_m, pick, done;

  cordic_stream_arbiter #(.DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .s00_axis_aclk(s00_axis_aclk), .s00_axis_aresetn(s00_axis_aresetn),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tlast(s00_axis_tlast),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tready(s00_axis_tready),
    .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tlast(s01_axis_tlast),
    .s01_axis_tdata(s01_axis_tdata), .s01_axis_tready(s01_axis_tready),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tlast(m00_axis_tlast),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tready(m00_axis_tready),
    .s02_axis_tvalid(s02_axis_tvalid), .s02_axis_tlast(s02_axis_tlast),
    .s02_axis_tdata(s02_axis_tdata), .s02_axis_tready(s02_axis_tready),
    .m01_axis_tvalid(m01_axis_tvalid), .m01_axis_tlast(m01_axis_tlast),
    .m01_axis_tdata(m01_axis_tdata), .m01_axis_tready(m01_axis_tready),
    .m02_axis_tvalid(m02_axis_tvalid), .m02_axis_tlast(m02_axis_tlast),
    .m02_axis_tdata(m02_axis_tdata), .m02_axis_tready(m02_axis_tready),
    .grant(grant), .tags_in_flight(tags_in_flight)
  );

  always #5 s00_axis_aclk = ~s00_axis_aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic clk_in();
    @(posedge s00_axis_aclk);
    #1;
  endtask

  task automatic smp();
    @(negedge s00_axis_aclk);
  endtask

  // Stand-in for the CORDIC computation on a returned beat.
  function automatic logic [63:0] xform(input logic [63:0] d);
    return {d[31:0] ^ 32'hC0DE_1234, d[63:32] + 32'h0000_0001};
  endfunction

  task automatic send_one(input logic src, input logic [63:0] d);
    logic got;
    got = 1'b0;
    clk_in();
    m00_axis_tready = 1'b1;
    if (src) begin
      s01_axis_tvalid = 1'b1; s01_axis_tlast = 1'b1; s01_axis_tdata = d;
    end else begin
      s00_axis_tvalid = 1'b1; s00_axis_tlast = 1'b1; s00_axis_tdata = d;
    end
    for (int i = 0; i < 8; i++) begin
      smp();
      if (m00_axis_tvalid === 1'b1) begin
        got = 1'b1;
        chk("send_grant", grant, src ? 64'd2 : 64'd1);
        chk("send_data", m00_axis_tdata, d);
      end
      clk_in();
      if (got) break;
    end
    s00_axis_tvalid = 1'b0; s00_axis_tlast = 1'b0;
    s01_axis_tvalid = 1'b0; s01_axis_tlast = 1'b0;
    chk("send_handshake", got, 1);
  endtask

  initial begin
    s00_axis_aresetn = 1'b0;
    s00_axis_tvalid = 1'b1; s00_axis_tlast = 1'b0; s00_axis_tdata = 64'h0;
    s01_axis_tvalid = 1'b0; s01_axis_tlast = 1'b0; s01_axis_tdata = 64'h0;
    m00_axis_tready = 1'b0;
    s02_axis_tvalid = 1'b1; s02_axis_tlast = 1'b0; s02_axis_tdata = 64'h0;
    m01_axis_tready = 1'b1; m02_axis_tready = 1'b1;

    // Reset state with inputs active.
    smp();
    chk("rst_grant", grant, 0);
    chk("rst_tags", tags_in_flight, 0);
    chk("rst_s00_tready", s00_axis_tready, 0);
    chk("rst_m00_tvalid", m00_axis_tvalid, 0);
    chk("rst_s02_tready", s02_axis_tready, 0);
    chk("rst_m01_tvalid", m01_axis_tvalid, 0);
    s00_axis_tvalid = 1'b0; s02_axis_tvalid = 1'b0;
    m01_axis_tready = 1'b0; m02_axis_tready = 1'b0;
    repeat (2) clk_in();
    s00_axis_aresetn = 1'b1;
    repeat (4) clk_in();

    // Single requester, 3-beat packet.
    s00_axis_tvalid = 1'b1; s00_axis_tdata = 64'h11; m00_axis_tready = 1'b1;
    smp();
    chk("single_idle_grant", grant, 0);
    clk_in();
    smp();
    chk("single_grant", grant, 1);
    chk("single_beat1", m00_axis_tdata, 64'h11);
    chk("single_tags", tags_in_flight, 1);
    chk("single_s01_tready", s01_axis_tready, 0);
    clk_in(); s00_axis_tdata = 64'h22;
    smp();
    chk("single_beat2", m00_axis_tdata, 64'h22);
    clk_in(); s00_axis_tdata = 64'h33; s00_axis_tlast = 1'b1;
    smp();
    chk("single_beat3", m00_axis_tdata, 64'h33);
    chk("single_last", m00_axis_tlast, 1);
    clk_in(); s00_axis_tvalid = 1'b0; s00_axis_tlast = 1'b0;
    smp();
    chk("single_bubble_grant", grant, 0);
    chk("single_bubble_valid", m00_axis_tvalid, 0);
    clk_in();
    s02_axis_tvalid = 1'b1; s02_axis_tlast = 1'b1; s02_axis_tdata = 64'h77; m01_axis_tready = 1'b1;
    smp();
    chk("single_ret_valid", m01_axis_tvalid, 1);
    chk("single_ret_data", m01_axis_tdata, 64'h77);
    chk("single_ret_m02", m02_axis_tvalid, 0);
    chk("single_ret_ready", s02_axis_tready, 1);
    clk_in(); s02_axis_tvalid = 1'b0;
    smp();
    chk("single_drained", tags_in_flight, 0);

    // Tag FIFO full: four single-beat packets, no results returned.
    clk_in();
    s00_axis_tvalid = 1'b1; s00_axis_tlast = 1'b1; s00_axis_tdata = 64'h100;
    repeat (10) clk_in();
    smp();
    chk("full_tags", tags_in_flight, 4);
    chk("full_grant", grant, 0);
    chk("full_s00_tready", s00_axis_tready, 0);
    chk("full_m00_tvalid", m00_axis_tvalid, 0);
    clk_in();
    s02_axis_tvalid = 1'b1; s02_axis_tlast = 1'b1; s02_axis_tdata = 64'h5;
    smp();
    chk("full_ret_ready", s02_axis_tready, 1);
    clk_in(); s02_axis_tvalid = 1'b0;
    smp();
    chk("full_pop_tags", tags_in_flight, 3);
    chk("full_pop_grant", grant, 0);
    clk_in();
    smp();
    chk("full_regrant", grant, 1);
    chk("full_regrant_tags", tags_in_flight, 4);
    clk_in(); s00_axis_tvalid = 1'b0; s00_axis_tlast = 1'b0;
    smp();
    chk("full_after_grant", grant, 0);
    clk_in();
    s02_axis_tvalid = 1'b1; s02_axis_tlast = 1'b1;
    repeat (4) clk_in();
    s02_axis_tvalid = 1'b0;
    smp();
    chk("full_drained", tags_in_flight, 0);

    // Return routing with tags {0,1,0}.
    send_one(1'b0, 64'h0A);
    send_one(1'b1, 64'h0B);
    send_one(1'b0, 64'h0C);
    smp();
    chk("route_tags", tags_in_flight, 3);
    clk_in();
    m01_axis_tready = 1'b1; m02_axis_tready = 1'b0;
    s02_axis_tvalid = 1'b1; s02_axis_tlast = 1'b1; s02_axis_tdata = {32'hAAAA0000, 32'h1};
    smp();
    chk("route_a_m01_valid", m01_axis_tvalid, 1);
    chk("route_a_m01_data", m01_axis_tdata, {32'hAAAA0000, 32'h1});
    chk("route_a_m02_valid", m02_axis_tvalid, 0);
    chk("route_a_m02_data", m02_axis_tdata, 0);
    clk_in(); s02_axis_tdata = {32'hBBBB0000, 32'h2};
    smp();
    chk("route_b_m02_valid", m02_axis_tvalid, 1);
    chk("route_b_stall_ready", s02_axis_tready, 0);
    chk("route_b_m01_valid", m01_axis_tvalid, 0);
    chk("route_b_m01_data", m01_axis_tdata, 0);
    clk_in();
    smp();
    chk("route_b_still_stalled", s02_axis_tready, 0);
    chk("route_b_tags", tags_in_flight, 2);
    clk_in(); m02_axis_tready = 1'b1;
    smp();
    chk("route_b_ready", s02_axis_tready, 1);
    chk("route_b_m02_data", m02_axis_tdata, {32'hBBBB0000, 32'h2});
    clk_in(); s02_axis_tdata = {32'hCCCC0000, 32'h3};
    smp();
    chk("route_c_m01_valid", m01_axis_tvalid, 1);
    chk("route_c_m01_data", m01_axis_tdata, {32'hCCCC0000, 32'h3});
    chk("route_c_m02_valid", m02_axis_tvalid, 0);
    clk_in(); s02_axis_tvalid = 1'b0;
    smp();
    chk("route_drained", tags_in_flight, 0);

    // Reset in the middle of a packet.
    clk_in();
    s00_axis_tvalid = 1'b1; s00_axis_tlast = 1'b0; s00_axis_tdata = 64'h55; m00_axis_tready = 1'b1;
    clk_in();
    smp();
    chk("midrst_pre_grant", grant, 1);
    clk_in();
    s00_axis_aresetn = 1'b0; s02_axis_tvalid = 1'b1;
    smp();
    chk("midrst_grant", grant, 0);
    chk("midrst_tags", tags_in_flight, 0);
    chk("midrst_s00_tready", s00_axis_tready, 0);
    chk("midrst_m00_tvalid", m00_axis_tvalid, 0);
    chk("midrst_s02_tready", s02_axis_tready, 0);
    clk_in();
    s00_axis_tvalid = 1'b0; s02_axis_tvalid = 1'b0; s00_axis_aresetn = 1'b1;
    repeat (4) clk_in();
    smp();
    chk("midrst_release_grant", grant, 0);

    // Randomized run: build packets, then predict the arbitration order at packet level.
    for (int p = 0; p < 10; p++) begin
      len = $urandom_range(1, 4);
      lens0.push_back(len);
      for (int k = 0; k < len; k++) begin
        b.src = 1'b0; b.last = (k == len - 1); b.data = {$urandom(), $urandom()};
        req_q0.push_back(b);
      end
      len = $urandom_range(1, 4);
      lens1.push_back(len);
      for (int k = 0; k < len; k++) begin
        b.src = 1'b1; b.last = (k == len - 1); b.data = {$urandom(), $urandom()};
        req_q1.push_back(b);
      end
    end
    tmp0 = req_q0;
    tmp1 = req_q1;
    rr_m = 1'b0;
    while (lens0.size() + lens1.size() != 0) begin
      if (lens0.size() != 0 && lens1.size() != 0) pick = rr_m;
      else pick = (lens1.size() != 0);
      len = pick ? lens1.pop_front() : lens0.pop_front();
      for (int k = 0; k < len; k++) begin
        b = pick ? tmp1.pop_front() : tmp0.pop_front();
        fwd_exp.push_back(b);
        b.data = xform(b.data);
        if (pick) ret1.push_back(b);
        else ret0.push_back(b);
      end
      rr_m = ~pick;
    end

    clk_in();
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      s00_axis_tvalid = (req_q0.size() != 0);
      s00_axis_tdata  = (req_q0.size() != 0) ? req_q0[0].data : 64'h0;
      s00_axis_tlast  = (req_q0.size() != 0) ? req_q0[0].last : 1'b0;
      s01_axis_tvalid = (req_q1.size() != 0);
      s01_axis_tdata  = (req_q1.size() != 0) ? req_q1[0].data : 64'h0;
      s01_axis_tlast  = (req_q1.size() != 0) ? req_q1[0].last : 1'b0;
      m00_axis_tready = ($urandom_range(0, 3) != 0);
      s02_axis_tvalid = (cord_q.size() != 0) && ($urandom_range(0, 2) != 0);
      s02_axis_tdata  = (cord_q.size() != 0) ? xform(cord_q[0].data) : 64'h0;
      s02_axis_tlast  = (cord_q.size() != 0) ? cord_q[0].last : 1'b0;
      m01_axis_tready = ($urandom_range(0, 2) != 0);
      m02_axis_tready = ($urandom_range(0, 2) != 0);
      smp();
      chk("rnd_leak0", s00_axis_tready && (grant != 2'b01), 0);
      chk("rnd_leak1", s01_axis_tready && (grant != 2'b10), 0);
      chk("rnd_ret_excl", m01_axis_tvalid && m02_axis_tvalid, 0);
      chk("rnd_tag_max", tags_in_flight <= 3'd4, 1);
      if (s00_axis_tvalid && s00_axis_tready) void'(req_q0.pop_front());
      if (s01_axis_tvalid && s01_axis_tready) void'(req_q1.pop_front());
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (fwd_exp.size() == 0) begin
          chk("rnd_fwd_extra", m00_axis_tvalid, 0);
        end else begin
          e = fwd_exp.pop_front();
          chk("rnd_fwd_data", m00_axis_tdata, e.data);
          chk("rnd_fwd_last", m00_axis_tlast, e.last);
          chk("rnd_fwd_grant", grant, e.src ? 64'd2 : 64'd1);
          b.src = e.src; b.last = m00_axis_tlast; b.data = m00_axis_tdata;
          cord_q.push_back(b);
        end
      end
      if (s02_axis_tvalid && s02_axis_tready && cord_q.size() != 0) void'(cord_q.pop_front());
      if (m01_axis_tvalid && m01_axis_tready) begin
        if (ret0.size() == 0) begin
          chk("rnd_ret0_extra", m01_axis_tvalid, 0);
        end else begin
          e = ret0.pop_front();
          chk("rnd_ret0_data", m01_axis_tdata, e.data);
          chk("rnd_ret0_last", m01_axis_tlast, e.last);
        end
      end
      if (m02_axis_tvalid && m02_axis_tready) begin
        if (ret1.size() == 0) begin
          chk("rnd_ret1_extra", m02_axis_tvalid, 0);
        end else begin
          e = ret1.pop_front();
          chk("rnd_ret1_data", m02_axis_tdata, e.data);
          chk("rnd_ret1_last", m02_axis_tlast, e.last);
        end
      end
      clk_in();
      cyc++;
      done = (fwd_exp.size() == 0) && (ret0.size() == 0) && (ret1.size() == 0) && (cord_q.size() == 0);
    end
    chk("rnd_completed", done, 1);
    s00_axis_tvalid = 1'b0; s01_axis_tvalid = 1'b0; s02_axis_tvalid = 1'b0;
    smp();
    chk("rnd_final_tags", tags_in_flight, 0);
    chk("rnd_final_grant", grant, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cordic_stream_arbiter.md
Name: cordic_stream_arbiter

Overview:
- Shares one CORDIC AXI-Stream pipeline between two requesters.
- Packet-level round-robin arbitration on the forward path; the grant is locked until the tlast beat completes.
- Records the source of every granted packet in a tag FIFO and uses it to route each CORDIC result packet back to its requester.
- Sits between the sample sources and the CORDIC. Observers on the CORDIC output (monitors/snoopers) stay passive.

Parameters:
- DATA_WIDTH, 64, tdata width on all stream ports ([31:0] magnitude, [63:32] angle on the return path).
- TAG_DEPTH, 4, maximum packets in flight inside the CORDIC; power of two, at least 2.

Ports:
- s00_axis_aclk  in  1  sole clock.
- s00_axis_aresetn  in  1  asynchronous active-low reset.
- s00_axis_tvalid/tlast  in  1 each  requester 0 forward stream.
- s00_axis_tdata  in  DATA_WIDTH  requester 0 forward data.
- s00_axis_tready  out  1  requester 0 ready.
- s01_axis_tvalid/tlast  in  1 each  requester 1 forward stream.
- s01_axis_tdata  in  DATA_WIDTH  requester 1 forward data.
- s01_axis_tready  out  1  requester 1 ready.
- m00_axis_tvalid/tlast  out  1 each  stream to CORDIC.
- m00_axis_tdata  out  DATA_WIDTH  data to CORDIC.
- m00_axis_tready  in  1  CORDIC ready.
- s02_axis_tvalid/tlast  in  1 each  CORDIC result stream.
- s02_axis_tdata  in  DATA_WIDTH  CORDIC result data.
- s02_axis_tready  out  1  result ready.
- m01_axis_tvalid/tlast  out  1 each  result stream to requester 0.
- m01_axis_tdata  out  DATA_WIDTH  result data to requester 0.
- m01_axis_tready  in  1  requester 0 result ready.
- m02_axis_tvalid/tlast  out  1 each  result stream to requester 1.
- m02_axis_tdata  out  DATA_WIDTH  result data to requester 1.
- m02_axis_tready  in  1  requester 1 result ready.
- grant  out  2  one-hot active forward grant; 00 when idle.
- tags_in_flight  out  $clog2(TAG_DEPTH+1)  tag FIFO occupancy.

Behaviour:
Reset:
- Asynchronous assert, synchronous release.
- Clears state to IDLE, rr pointer to 0, tag FIFO pointers and count to 0.
- All tvalid/tready outputs, grant and tags_in_flight are 0.
- A packet in flight at reset is abandoned; no recovery.

Forward FSM, states IDLE, BUSY0, BUSY1:
- IDLE: all s0x_tready=0, m00_tvalid=0. If count<TAG_DEPTH and any s0x_tvalid is high, select a source.
  - Both valid: pick rr (rr=0 favours s00).
  - One valid: pick that one.
  - Next cycle the state is BUSYx, the tag x is pushed, and grant is set.
- BUSYx: combinational pass-through. m00_tvalid=s0x_tvalid, m00_tdata/tlast=s0x_tdata/tlast, s0x_tready=m00_tready. The other requester's tready stays 0.
- Handshake with tlast=1 in BUSYx: next state IDLE, rr <= ~x. There is exactly one idle bubble cycle between packets.
- The grant never changes mid-packet, regardless of the other requester's valid.
- Count=TAG_DEPTH in IDLE: no grant; requesters stall.

Tag FIFO:
- TAG_DEPTH entries of 1 bit each, with separate read and write pointers.
- Push and pop in the same cycle is legal; count is unchanged.

Return path:
- FIFO empty: s02_tready=0, m01/m02_tvalid=0.
- Head tag h selects the output: h=0 drives m01, h=1 drives m02.
  - Selected output: tvalid=s02_tvalid, tdata/tlast from s02.
  - s02_tready equals the selected output's tready.
  - Unselected output: tvalid=0, tdata=0, tlast=0.
- Pop on an s02 handshake with tlast=1. The next beat routes by the new head; there is no bubble on the return path.
- The return path is independent of the forward FSM; both may be active in the same cycle.

Width and ordering rules:
- No data modification; all muxes are DATA_WIDTH.
- The CORDIC is assumed to be in-order, one result packet per input packet. The block does not check this.

Test Plan:
- Reset check: hold aresetn low mid-packet -> all valids/readies 0, grant=00, tags_in_flight=0 within the same cycle; after release, state is IDLE.
- Single requester: s00 sends a 3-beat packet 0x11,0x22,0x33 with tlast on the 3rd, m00_tready=1 -> grant=01 after 1 cycle. m00 carries the 3 beats in order, then a 1-cycle idle. tags_in_flight goes 0->1.
- Round-robin: s00 and s01 both continuously valid with 2-beat packets -> grant sequence 01,10,01,10. Neither tready is high outside its grant.
- Backpressure lock: m00_tready toggles 1,0,0,1 during an s01 packet while s00 is valid -> the grant stays 10 until s01's tlast handshake; no s00 beat leaks.
- Tag full: TAG_DEPTH=4, 4 single-beat packets sent, s02 idle -> tags_in_flight=4 and no 5th grant. One result with tlast returned -> count 3 and the next grant issues.
- Return routing: tags {0,1,0} queued, CORDIC returns 3 packets with angle 0xAAAA0000, 0xBBBB0000, 0xCCCC0000 in [63:32] -> m01, m02, m01 respectively. With m02_tready=0, s02_tready=0 until m02_tready rises.
